// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared scoreboard entry type, constants and width helpers
package hazard_pkg;

  localparam int DEST_MAX = 8;
  localparam int FWD_RF   = 0;

  typedef struct packed {
    logic                valid;
    logic                regwrite;
    logic                is_load;
    logic [DEST_MAX-1:0] dest;
  } sb_entry_t;

  function automatic int bits_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - youngest-match priority encoder for one source operand
module hazard_match
  import hazard_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int LOAD_LAT   = 2,
  parameter int AW         = 5,
  parameter int FW         = 2
) (
  input  sb_entry_t [PIPE_DEPTH-1:0] entries_i,
  input  logic [AW-1:0]              src_addr_i,
  input  logic                       src_used_i,
  output logic                       hit_o,
  output logic [FW-1:0]              index_o,
  output logic                       ready_o
);

  // Scan oldest to youngest so the youngest candidate is the last to overwrite.
  always_comb begin
    hit_o   = 1'b0;
    index_o = '0;
    ready_o = 1'b1;
    for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
      if (src_used_i && (src_addr_i != '0) && entries_i[i].valid &&
          entries_i[i].regwrite && (entries_i[i].dest == DEST_MAX'(src_addr_i))) begin
        hit_o   = 1'b1;
        index_o = FW'(i);
        ready_o = !entries_i[i].is_load || (i + 1 >= LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight destination scoreboard driving decode stall and EX forward selects
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int PIPE_DEPTH   = 3,
  parameter int NUM_SRC      = 2,
  parameter int LOAD_LAT     = 2,
  parameter int FLUSH_STAGES = 0,
  parameter int CNT_W        = 16,
  localparam int AW = bits_for(NUM_REGS),
  localparam int FW = bits_for(PIPE_DEPTH),
  localparam int IW = bits_for(PIPE_DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ip_issue_valid,
  input  logic                  ip_issue_regwrite,
  input  logic                  ip_issue_is_load,
  input  logic [AW-1:0]         ip_issue_dest,
  input  logic [NUM_SRC*AW-1:0] ip_src_addr,
  input  logic [NUM_SRC-1:0]    ip_src_used,
  input  logic                  ip_flush,
  output logic                  op_stall,
  output logic [NUM_SRC*FW-1:0] op_fwd_sel,
  output logic [IW-1:0]         op_inflight,
  output logic [CNT_W-1:0]      op_stall_count
);

  sb_entry_t [PIPE_DEPTH-1:0] entry_q, entry_d;
  logic [NUM_SRC*FW-1:0]      fwd_sel_q, fwd_sel_d;
  logic [CNT_W-1:0]           stall_cnt_q, stall_cnt_d;

  logic [NUM_SRC-1:0] hit;
  logic [NUM_SRC-1:0] ready;
  logic [FW-1:0]      idx [NUM_SRC];
  logic               accept;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_match
    hazard_match #(
      .PIPE_DEPTH(PIPE_DEPTH),
      .LOAD_LAT  (LOAD_LAT),
      .AW        (AW),
      .FW        (FW)
    ) u_match (
      .entries_i (entry_q),
      .src_addr_i(ip_src_addr[g*AW +: AW]),
      .src_used_i(ip_src_used[g]),
      .hit_o     (hit[g]),
      .index_o   (idx[g]),
      .ready_o   (ready[g])
    );
  end

  assign op_stall = ip_issue_valid & ~ip_flush & (|(hit & ~ready));
  assign accept   = ip_issue_valid & ~op_stall & ~ip_flush;

  always_comb begin
    entry_d = '0;
    if (accept) begin
      entry_d[0] = '{valid: 1'b1, regwrite: ip_issue_regwrite,
                     is_load: ip_issue_is_load, dest: DEST_MAX'(ip_issue_dest)};
    end
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      entry_d[i] = (ip_flush && (i <= FLUSH_STAGES)) ? '0 : entry_q[i-1];
    end
  end

  // A winner at i sits at i+1 when this instruction reaches EX; past WB it is in the register file.
  always_comb begin
    fwd_sel_d = '0;
    if (accept) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (hit[s] && (int'(idx[s]) + 1 <= PIPE_DEPTH - 1)) begin
          fwd_sel_d[s*FW +: FW] = idx[s] + FW'(1);
        end else begin
          fwd_sel_d[s*FW +: FW] = FW'(FWD_RF);
        end
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (op_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    op_inflight = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      op_inflight = op_inflight + IW'(entry_q[i].valid & entry_q[i].regwrite);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      entry_q     <= '0;
      fwd_sel_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      entry_q     <= entry_d;
      fwd_sel_q   <= fwd_sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign op_fwd_sel     = fwd_sel_q;
  assign op_stall_count = stall_cnt_q;

endmodule
